// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream handshake between image source and boot loader
interface imem_boot_loader_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (output rx_valid, output rx_data, input rx_ready);
   modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - assembles a byte stream into instruction memory words and gates core reset
module imem_boot_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   imem_boot_loader_if.slave     rx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  loading,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_FLUSH,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [23:0]           word_q, word_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  core_reset_q, core_reset_d;
   logic                  loading_q, loading_d;
   logic                  load_error_q, load_error_d;
   logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;

   logic        accept;
   logic        timeout;
   logic        last_word;
   logic [15:0] new_len;

   // Ready only in byte-consuming states, and never while reset is held.
   assign rx.rx_ready = ~reset & ((state_q == S_LEN_HI) | (state_q == S_LEN_LO) | (state_q == S_DATA));
   assign accept      = rx.rx_valid & rx.rx_ready;
   assign new_len     = {len_q[15:8], rx.rx_data};
   // An accept on the limit cycle wins; the caller checks accept first.
   assign timeout     = (timer_q + TW'(1)) == TW'(TIMEOUT_CYCLES);
   // words_loaded already counts every earlier word when byte 3 of the next one lands.
   assign last_word   = 32'(words_loaded_q) == (32'(len_q) - 32'd1);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      word_d         = word_q;
      byte_idx_d     = byte_idx_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      words_loaded_d = words_loaded_q + {{ADDR_WIDTH{1'b0}}, imem_we_q};

      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = rx.rx_data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx.rx_data;
               if (new_len == 16'd0)
                  state_d = S_RUN;
               else if (32'(new_len) > (32'd1 << ADDR_WIDTH))
                  state_d = S_ERROR;
               else
                  state_d = S_DATA;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d     = {word_q[15:0], rx.rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_wdata_d = {word_q, rx.rx_data};
                  imem_addr_d  = words_loaded_q[ADDR_WIDTH-1:0];
                  if (last_word)
                     state_d = S_FLUSH;
               end
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_FLUSH: state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase

      if (accept || (state_d != state_q))
         timer_d = '0;
      else if ((state_q == S_LEN_LO) || (state_q == S_DATA))
         timer_d = timer_q + TW'(1);
      else
         timer_d = timer_q;

      core_reset_d = (state_d != S_RUN);
      loading_d    = (state_d != S_RUN) && (state_d != S_ERROR);
      load_error_d = (state_d == S_ERROR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_LEN_HI;
         len_q          <= '0;
         word_q         <= '0;
         byte_idx_q     <= '0;
         timer_q        <= '0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= '0;
         core_reset_q   <= 1'b1;
         loading_q      <= 1'b1;
         load_error_q   <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         word_q         <= word_d;
         byte_idx_q     <= byte_idx_d;
         timer_q        <= timer_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         core_reset_q   <= core_reset_d;
         loading_q      <= loading_d;
         load_error_q   <= load_error_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign core_reset   = core_reset_q;
   assign loading      = loading_q;
   assign load_error   = load_error_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        loading;
   logic        load_error;
   logic [8:0]  words_loaded;

   int checks = 0;
   int errors = 0;

   logic [7:0]  wr_addr [$];
   logic [31:0] wr_data [$];

   imem_boot_loader_if bus ();

   imem_boot_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (bus.slave),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .loading      (loading),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic do_reset();
      reset        = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      #1;
      while (bus.rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_byte ready timeout byte=%h", b);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0", bus.rx_ready); end
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr got=%h exp=00", imem_addr); end
      checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata got=%h exp=0", imem_wdata); end
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
      checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reset_loading got=%b exp=1", loading); end
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error got=%b exp=0", load_error); end
      checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL reset_words_loaded got=%0d exp=0", words_loaded); end
      reset        = 1'b0;
      bus.rx_valid = 1'b0;
      #1;
      checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_rx_ready got=%b exp=1", bus.rx_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] s [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
      do_reset();
      for (int i = 0; i < 10; i++) send_byte(s[i]);
      checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL basic_flush_we got=%b exp=1", imem_we); end
      checks++; if (imem_addr !== 8'd1) begin errors++; $display("FAIL basic_flush_addr got=%h exp=01", imem_addr); end
      checks++; if (imem_wdata !== 32'h12345678) begin errors++; $display("FAIL basic_flush_wdata got=%h exp=12345678", imem_wdata); end
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL basic_flush_core_reset got=%b exp=1", core_reset); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL basic_flush_rx_ready got=%b exp=0", bus.rx_ready); end
      bus.rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL basic_core_reset got=%b exp=0", core_reset); end
      checks++; if (loading !== 1'b0) begin errors++; $display("FAIL basic_loading got=%b exp=0", loading); end
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL basic_load_error got=%b exp=0", load_error); end
      checks++; if (words_loaded !== 9'd2) begin errors++; $display("FAIL basic_words_loaded got=%0d exp=2", words_loaded); end
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL basic_we_after got=%b exp=0", imem_we); end
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL basic_write_count got=%0d exp=2", wr_addr.size());
      end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDEADBEEF || wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h12345678) begin
         errors++; $display("FAIL basic_writes got=(%h,%h)(%h,%h) exp=(00,deadbeef)(01,12345678)", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_bubbles();
      logic [7:0] s [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
      int         g [10] = '{2, 0, 3, 1, 15, 0, 4, 1, 0, 2};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.rx_valid = 1'b0;
         repeat (g[i]) @(negedge clk);
         send_byte(s[i]);
      end
      bus.rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL bubbles_load_error got=%b exp=0", load_error); end
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL bubbles_core_reset got=%b exp=0", core_reset); end
      checks++; if (words_loaded !== 9'd2) begin errors++; $display("FAIL bubbles_words_loaded got=%0d exp=2", words_loaded); end
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL bubbles_write_count got=%0d exp=2", wr_addr.size());
      end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDEADBEEF || wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h12345678) begin
         errors++; $display("FAIL bubbles_writes got=(%h,%h)(%h,%h) exp=(00,deadbeef)(01,12345678)", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_zero();
      do_reset();
      send_byte(8'h00);
      send_byte(8'h00);
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL zero_core_reset got=%b exp=0", core_reset); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL zero_rx_ready got=%b exp=0", bus.rx_ready); end
      bus.rx_data = 8'h99;
      repeat (4) @(negedge clk);
      bus.rx_valid = 1'b0;
      #1;
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL zero_core_reset_hold got=%b exp=0", core_reset); end
      checks++; if (loading !== 1'b0) begin errors++; $display("FAIL zero_loading got=%b exp=0", loading); end
      checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL zero_words_loaded got=%0d exp=0", words_loaded); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_write_count got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'h01);
      send_byte(8'h01);
      checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL over_load_error got=%b exp=1", load_error); end
      checks++; if (loading !== 1'b0) begin errors++; $display("FAIL over_loading got=%b exp=0", loading); end
      repeat (4) @(negedge clk);
      bus.rx_valid = 1'b0;
      #1;
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL over_core_reset got=%b exp=1", core_reset); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL over_rx_ready got=%b exp=0", bus.rx_ready); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL over_write_count got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_full();
      int bad = 0;
      do_reset();
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i));
         send_byte(~8'(i));
         send_byte(8'h5A);
         send_byte(8'(i + 3));
      end
      bus.rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL full_load_error got=%b exp=0", load_error); end
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL full_core_reset got=%b exp=0", core_reset); end
      checks++; if (words_loaded !== 9'd256) begin errors++; $display("FAIL full_words_loaded got=%0d exp=256", words_loaded); end
      checks++;
      if (wr_addr.size() != 256) begin
         errors++; $display("FAIL full_write_count got=%0d exp=256", wr_addr.size());
      end else begin
         for (int i = 0; i < 256; i++) begin
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'(i), ~8'(i), 8'h5A, 8'(i + 3)}) bad++;
         end
         if (bad != 0) begin errors++; $display("FAIL full_writes got=%0d bad entries exp=0 (last addr %h data %h)", bad, wr_addr[255], wr_data[255]); end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      bus.rx_valid = 1'b0;
      repeat (15) @(negedge clk);
      checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0 at 15 cycles", load_error); end
      @(negedge clk);
      checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL timeout_at_16 got=%b exp=1", load_error); end
      checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL timeout_core_reset got=%b exp=1", core_reset); end
      checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL timeout_rx_ready got=%b exp=0", bus.rx_ready); end
      #1;
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL timeout_write_count got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'hCA);
      send_byte(8'hFE);
      bus.rx_valid = 1'b0;
      reset        = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (loading !== 1'b1) begin errors++; $display("FAIL mid_loading got=%b exp=1", loading); end
      checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL mid_words_loaded got=%0d exp=0", words_loaded); end
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      bus.rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL mid_core_reset got=%b exp=0", core_reset); end
      checks++; if (words_loaded !== 9'd1) begin errors++; $display("FAIL mid_words_final got=%0d exp=1", words_loaded); end
      checks++;
      if (wr_addr.size() != 1) begin
         errors++; $display("FAIL mid_write_count got=%0d exp=1", wr_addr.size());
      end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h11223344) begin
         errors++; $display("FAIL mid_write got=(%h,%h) exp=(00,11223344)", wr_addr[0], wr_data[0]);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic();
      test_bubbles();
      test_zero();
      test_oversize();
      test_full();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time loader that sits directly upstream of the instruction fetch stage. It receives a program image as a byte stream with a valid/ready handshake and assembles 32-bit words. It writes those words into the write port of the instruction memory. It holds the core in reset until the image is fully written, then releases the core to fetch from word 0. Load errors keep the core in reset.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address bits (capacity 2**ADDR_WIDTH words)
TIMEOUT_CYCLES, 1000000, idle cycles allowed mid-transfer before abort (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
rx_valid  input  1  byte available on rx_data
rx_data  input  8  stream byte
rx_ready  output  1  loader can accept a byte
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address; the core fetches with PC[ADDR_WIDTH+1:2]
imem_wdata  output  32  assembled instruction word
core_reset  output  1  reset to the datapath, high until load completes
loading  output  1  load in progress
load_error  output  1  sticky error flag
words_loaded  output  ADDR_WIDTH+1  count of words written

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. All state updates occur on the rising edge of clk.
- Byte transfer: a byte is accepted on a rising edge where rx_valid & rx_ready.
- rx_ready is combinational from state, gated low while reset=1.
- Reset values:
  - state=LEN_HI
  - imem_we=0, imem_addr=0, imem_wdata=0
  - core_reset=1, loading=1, load_error=0
  - words_loaded=0, byte index=0, length=0, timeout counter=0
- Stream format: 16-bit word count N, big-endian (high byte first), then N words. Each word is 4 bytes, big-endian; the first byte goes to bits [31:24].
- States:
  - LEN_HI: rx_ready=1; waits indefinitely, no timeout. On accept, latch N[15:8] and go to LEN_LO.
  - LEN_LO: rx_ready=1. On accept, latch N[7:0], then:
    - N==0 -> RUN.
    - N>2**ADDR_WIDTH -> ERROR.
    - Otherwise -> DATA.
  - DATA: rx_ready=1. Bytes shift into the word register and the byte index counts 0..3 and wraps.
    - On acceptance of byte 3: register imem_wdata=word and imem_addr=current word index; imem_we=1 during the following cycle only.
    - If this is word N-1, go to FLUSH; otherwise stay in DATA and keep accepting (the write strobe overlaps the next byte).
  - FLUSH: rx_ready=0; lasts one cycle, the cycle in which the final imem_we=1. Then -> RUN.
  - RUN: core_reset=0, loading=0, rx_ready=0; input is ignored. Only reset leaves RUN.
  - ERROR: core_reset=1, loading=0, load_error=1, rx_ready=0; sticky until reset. Words already written stay in memory.
- Latency:
  - imem_we is asserted in the cycle after byte 3 of a word is accepted.
  - core_reset deasserts on the edge ending the final imem_we cycle.
  - For N==0, core_reset deasserts on the edge after the LEN_LO accept.
- words_loaded increments on each edge where imem_we=1. It saturates naturally at 2**ADDR_WIDTH because N is range-checked.
- imem_addr: the word index for word 2**ADDR_WIDTH-1 is the last valid address; no wrap ever occurs.
- Timeout:
  - The counter is cleared on every accepted byte and on every state change.
  - It increments each cycle in LEN_LO or DATA with no accept.
  - Reaching TIMEOUT_CYCLES -> ERROR. A partial word is discarded and imem_we is not asserted.
- Reset mid-operation: all registers return to reset values on the next edge. A pending imem_we is cancelled, partial bytes are dropped, and loading restarts at LEN_HI.
- Simultaneous events: an accept in the same cycle that the timeout counter would reach its limit counts as an accept (no error).

Test Plan:
1. N=2; bytes 00 02 DE AD BE EF 12 34 56 78 with rx_valid held high -> expect:
   - imem_we pulses (addr 0, DEADBEEF) then (addr 1, 12345678);
   - words_loaded=2;
   - core_reset falls one cycle after the second pulse; loading=0; load_error=0.
2. Same stream as 1 with random rx_valid bubbles (gaps < TIMEOUT_CYCLES) -> identical writes and final state; no imem_we during bubbles.
3. N=0 (bytes 00 00) -> no imem_we; core_reset=0 from the cycle after the second byte; words_loaded=0; further bytes are ignored (rx_ready=0).
4. ADDR_WIDTH=8, N=257 (bytes 01 01) -> load_error=1, core_reset stays 1, no imem_we, rx_ready=0 thereafter.
5. TIMEOUT_CYCLES=16; N=1, then bytes AA BB, then rx_valid low -> load_error=1 exactly 16 cycles after BB was accepted; no write; core_reset remains 1.
6. Assert reset after 2 bytes of word 0, then send N=1 and 11 22 33 44 -> a single write (addr 0, 11223344) with no stale bytes; core_reset releases normally.
